// File: rtl/demo_cmd_gen.sv
// demo_cmd_gen: handshaked burst command generator for the graphics engine.
// Patterns (latched at start): 0 LFSR (XNOR taps, lock-up recovery),
// 1 increment, 2 constant, 3 walking-one. A beat is any cycle with
// o_cmd_valid && i_cmd_ready. The command register advances only on a beat.
// Handshake: o_cmd_valid is held high with o_command stable until
// i_cmd_ready is seen; the beat completes on that rising clock edge.
// Optional: define DEMO_CMD_STATS_EN to compile the saturating accepted-beat
// counter on o_cmd_count; otherwise o_cmd_count is tied to zero.
module demo_cmd_gen #(
   parameter int               CMD_W   = 52,
   parameter int               TAP_A   = 51,
   parameter int               TAP_B   = 48,
   parameter logic [CMD_W-1:0] SEED    = CMD_W'(1),
   parameter int               BURST_W = 8
) (
   input  logic               clk,
   input  logic               rst_,
   input  logic [1:0]         i_mode,
   input  logic               i_start,
   input  logic [BURST_W-1:0] i_burst_len,
   input  logic               i_seed_load,
   input  logic [CMD_W-1:0]   i_seed,
   input  logic               i_stop,
   output logic               o_cmd_valid,
   input  logic               i_cmd_ready,
   output logic [CMD_W-1:0]   o_command,
   output logic               o_busy,
   output logic               o_done,
   output logic [15:0]        o_cmd_count,
   output logic [1:0]         o_state
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t             r_state;
   state_t             w_state_nxt;
   logic [CMD_W-1:0]   r_command;
   logic [CMD_W-1:0]   w_cmd_nxt;
   logic [1:0]         r_mode;
   logic [BURST_W-1:0] r_burst_cnt;
   logic               w_idle;
   logic               w_beat;
   logic               w_final;

   assign w_idle  = (r_state == ST_IDLE);
   assign w_beat  = (r_state == ST_RUN) && i_cmd_ready;
   // A zero counter means continuous mode, so it never reaches the final beat.
   assign w_final = w_beat && (r_burst_cnt == BURST_W'(1));

   // State register.
   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state logic: stop and the final beat both end the burst.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: if (i_start) w_state_nxt = ST_RUN;
         ST_RUN:  if (w_final || i_stop) w_state_nxt = ST_DONE;
         ST_DONE: w_state_nxt = ST_IDLE;
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // Pattern advance, computed straight from the current command register.
   always_comb begin
      w_cmd_nxt = r_command;
      case (r_mode)
         2'd0: begin
            if (&r_command) begin
               w_cmd_nxt = SEED;
            end else begin
               w_cmd_nxt = {r_command[CMD_W-2:0], r_command[TAP_A] ~^ r_command[TAP_B]};
            end
         end
         2'd1: w_cmd_nxt = r_command + CMD_W'(1);
         2'd2: w_cmd_nxt = r_command;
         default: begin
            if (r_command == '0) begin
               w_cmd_nxt = CMD_W'(1);
            end else begin
               w_cmd_nxt = {r_command[CMD_W-2:0], r_command[CMD_W-1]};
            end
         end
      endcase
   end

   // Command register, latched mode and burst counter.
   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) begin
         r_command   <= SEED;
         r_mode      <= 2'd0;
         r_burst_cnt <= '0;
      end else if (w_idle) begin
         if (i_seed_load) r_command <= i_seed;
         if (i_start) begin
            r_mode      <= i_mode;
            r_burst_cnt <= i_burst_len;
         end
      end else if (w_beat) begin
         r_command <= w_cmd_nxt;
         if (r_burst_cnt != '0) r_burst_cnt <= r_burst_cnt - BURST_W'(1);
      end
   end

`ifdef DEMO_CMD_STATS_EN
   logic [15:0] r_cmd_count;

   // Accepted-beat counter: cleared on start, saturates at all ones.
   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) begin
         r_cmd_count <= 16'd0;
      end else if (w_idle && i_start) begin
         r_cmd_count <= 16'd0;
      end else if (w_beat && (r_cmd_count != 16'hFFFF)) begin
         r_cmd_count <= r_cmd_count + 16'd1;
      end
   end

   assign o_cmd_count = r_cmd_count;
`else
   assign o_cmd_count = 16'd0;
`endif

   assign o_cmd_valid = (r_state == ST_RUN);
   assign o_busy      = (r_state == ST_RUN);
   assign o_done      = (r_state == ST_DONE);
   assign o_command   = r_command;
   assign o_state     = r_state;

endmodule
